trng_word_sampler: RTL and testbench

TRNG_WORD_SAMPLER -- requirements
Module: trng_word_sampler

---
 rtl/trng_pkg.sv | 28 ++
 rtl/trng_word_sampler_core.sv | 39 +++
 rtl/trng_word_sampler.sv | 205 ++++++++++++++++++++
 tb/tb_trng_word_sampler.sv | 185 ++++++++++++++++++
 4 files changed

// File: rtl/trng_pkg.sv
// Shared types and parameter defaults for the TRNG word sampler and its entropy core.
package trng_pkg;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_WARMUP  = 3'd1,
        ST_COLLECT = 3'd2,
        ST_HOLD    = 3'd3,
        ST_FAIL    = 3'd4
    } state_e;

    localparam int DEF_NUM_OSCILLATORS = 128;
    localparam int DEF_NUM_INVERTER    = 5;
    localparam int DEF_WORD_WIDTH      = 32;
    localparam int DEF_DEBIAS          = 1;
    localparam int DEF_WARMUP_CYCLES   = 256;
    localparam int DEF_REP_LIMIT       = 32;

    // Counter width for a range 0..value-1, never narrower than one bit.
    function automatic int clog2_min1(input int value);
        if (value <= 2) begin
            return 1;
        end else begin
            return $clog2(value);
        end
    endfunction

endpackage

// File: rtl/trng_word_sampler_core.sv
// Synthesizable stand-in for the ring-oscillator entropy core: one phase bit per
// oscillator, advanced while enabled, with the last oscillator driving the output.
module trng_word_sampler_core
    import trng_pkg::*;
#(
    parameter int NUM_OSCILLATORS = DEF_NUM_OSCILLATORS,
    parameter int NUM_INVERTER    = DEF_NUM_INVERTER
) (
    input  logic clk,
    input  logic rst,
    input  logic en,
    output logic core_out
);

    localparam int TAP = NUM_INVERTER % (NUM_OSCILLATORS - 1);

    logic [NUM_OSCILLATORS-1:0] osc_q;
    logic [NUM_OSCILLATORS-1:0] osc_d;

    // Oscillator phases only advance while the sampler powers the core.
    always_comb begin
        if (en) begin
            osc_d = {osc_q[NUM_OSCILLATORS-2:0], osc_q[NUM_OSCILLATORS-1] ^ osc_q[TAP]};
        end else begin
            osc_d = osc_q;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            osc_q <= {{(NUM_OSCILLATORS-1){1'b0}}, 1'b1};
        end else begin
            osc_q <= osc_d;
        end
    end

    assign core_out = osc_q[NUM_OSCILLATORS-1];

endmodule

// File: rtl/trng_word_sampler.sv
// Samples raw entropy bits, optionally von Neumann debiases them, packs them into
// words with a valid/ready handshake, and runs a sticky repetition health test.
module trng_word_sampler
    import trng_pkg::*;
#(
    parameter int NUM_OSCILLATORS = DEF_NUM_OSCILLATORS,
    parameter int NUM_INVERTER    = DEF_NUM_INVERTER,
    parameter int WORD_WIDTH      = DEF_WORD_WIDTH,
    parameter int DEBIAS          = DEF_DEBIAS,
    parameter int WARMUP_CYCLES   = DEF_WARMUP_CYCLES,
    parameter int REP_LIMIT       = DEF_REP_LIMIT
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  enable,
    input  logic                  test_mode,
    input  logic                  test_bit,
    output logic [WORD_WIDTH-1:0] data_o,
    output logic                  valid_o,
    input  logic                  ready_i,
    output logic                  health_fail_o,
    output logic                  busy_o
);

    localparam int WARM_W = clog2_min1(WARMUP_CYCLES);
    localparam int BIT_W  = clog2_min1(WORD_WIDTH);
    localparam int RUN_W  = $clog2(REP_LIMIT + 1);
    localparam logic [WARM_W-1:0] WARM_LAST = WARM_W'(WARMUP_CYCLES - 1);
    localparam logic [BIT_W-1:0]  BIT_LAST  = BIT_W'(WORD_WIDTH - 1);
    localparam logic [RUN_W-1:0]  RUN_LIMIT = RUN_W'(REP_LIMIT);

    state_e                state_q, state_d;
    logic                  raw_q, raw_d, prev_q, prev_d;
    logic                  first_q, first_d, phase_q, phase_d;
    logic [WARM_W-1:0]     warm_cnt_q, warm_cnt_d;
    logic [BIT_W-1:0]      bit_cnt_q, bit_cnt_d;
    logic [RUN_W-1:0]      run_q, run_d, run_next;
    logic [WORD_WIDTH-1:0] data_q, data_d;
    logic                  valid_q, valid_d, fail_q, fail_d;
    logic                  accept, acc_bit, word_done, rep_fail, warm_last, drop;
    logic                  core_en, core_out;

    trng_word_sampler_core #(
        .NUM_OSCILLATORS (NUM_OSCILLATORS),
        .NUM_INVERTER    (NUM_INVERTER)
    ) u_core (
        .clk      (clk),
        .rst      (rst),
        .en       (core_en),
        .core_out (core_out)
    );

    // Per-cycle decisions on the registered raw bit; the first bit after a clear starts a run of one.
    always_comb begin
        if ((run_q != RUN_W'(0)) && (raw_q == prev_q)) begin
            run_next = run_q + RUN_W'(1);
        end else begin
            run_next = RUN_W'(1);
        end
        if (DEBIAS != 0) begin
            accept  = phase_q & (first_q ^ raw_q);
            acc_bit = first_q;
        end else begin
            accept  = 1'b1;
            acc_bit = raw_q;
        end
        word_done = accept && (bit_cnt_q == BIT_LAST);
        rep_fail  = (run_next == RUN_LIMIT);
        warm_last = (warm_cnt_q == WARM_LAST);
        drop      = !enable && ((state_q == ST_WARMUP) || (state_q == ST_COLLECT) || (state_q == ST_HOLD));
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (enable && !fail_q) state_d = ST_WARMUP;
                else                   state_d = ST_IDLE;
            end
            ST_WARMUP: begin
                if (!enable)        state_d = ST_IDLE;
                else if (warm_last) state_d = ST_COLLECT;
                else                state_d = ST_WARMUP;
            end
            ST_COLLECT: begin
                if (!enable)        state_d = ST_IDLE;
                else if (rep_fail)  state_d = ST_FAIL;
                else if (word_done) state_d = ST_HOLD;
                else                state_d = ST_COLLECT;
            end
            ST_HOLD: begin
                if (!enable)      state_d = ST_IDLE;
                else if (ready_i) state_d = ST_COLLECT;
                else              state_d = ST_HOLD;
            end
            ST_FAIL: state_d = ST_FAIL;
            default: state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        core_en = (state_q == ST_WARMUP) || (state_q == ST_COLLECT) || (state_q == ST_HOLD);
        busy_o  = (state_q == ST_WARMUP) || (state_q == ST_COLLECT);
    end

    // Datapath: dropping enable discards everything; failure wins over word completion.
    always_comb begin
        raw_d      = test_mode ? test_bit : core_out;
        prev_d     = prev_q;
        first_d    = first_q;
        phase_d    = phase_q;
        warm_cnt_d = warm_cnt_q;
        bit_cnt_d  = bit_cnt_q;
        run_d      = run_q;
        data_d     = data_q;
        valid_d    = valid_q;
        fail_d     = fail_q;
        if (drop) begin
            prev_d     = 1'b0;
            first_d    = 1'b0;
            phase_d    = 1'b0;
            warm_cnt_d = WARM_W'(0);
            bit_cnt_d  = BIT_W'(0);
            run_d      = RUN_W'(0);
            data_d     = {WORD_WIDTH{1'b0}};
            valid_d    = 1'b0;
        end else begin
            case (state_q)
                ST_WARMUP: warm_cnt_d = warm_last ? WARM_W'(0) : warm_cnt_q + WARM_W'(1);
                ST_COLLECT: begin
                    prev_d = raw_q;
                    run_d  = run_next;
                    if (rep_fail) begin
                        fail_d  = 1'b1;
                        data_d  = {WORD_WIDTH{1'b0}};
                        valid_d = 1'b0;
                    end else begin
                        phase_d = (DEBIAS != 0) ? ~phase_q : 1'b0;
                        first_d = raw_q;
                        if (accept) begin
                            data_d    = {data_q[WORD_WIDTH-2:0], acc_bit};
                            valid_d   = word_done;
                            bit_cnt_d = word_done ? bit_cnt_q : bit_cnt_q + BIT_W'(1);
                        end else begin
                            data_d = data_q;
                        end
                    end
                end
                ST_HOLD: begin
                    if (ready_i) begin
                        valid_d   = 1'b0;
                        bit_cnt_d = BIT_W'(0);
                        phase_d   = 1'b0;
                    end else begin
                        valid_d = valid_q;
                    end
                end
                ST_FAIL: begin
                    data_d  = {WORD_WIDTH{1'b0}};
                    valid_d = 1'b0;
                end
                default: valid_d = valid_q;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            raw_q      <= 1'b0;
            prev_q     <= 1'b0;
            first_q    <= 1'b0;
            phase_q    <= 1'b0;
            warm_cnt_q <= WARM_W'(0);
            bit_cnt_q  <= BIT_W'(0);
            run_q      <= RUN_W'(0);
            data_q     <= {WORD_WIDTH{1'b0}};
            valid_q    <= 1'b0;
            fail_q     <= 1'b0;
        end else begin
            raw_q      <= raw_d;
            prev_q     <= prev_d;
            first_q    <= first_d;
            phase_q    <= phase_d;
            warm_cnt_q <= warm_cnt_d;
            bit_cnt_q  <= bit_cnt_d;
            run_q      <= run_d;
            data_q     <= data_d;
            valid_q    <= valid_d;
            fail_q     <= fail_d;
        end
    end

    assign data_o        = data_q;
    assign valid_o       = valid_q;
    assign health_fail_o = fail_q;

endmodule

// File: tb/tb_trng_word_sampler.sv
// Directed bench: dut0 is raw (8-bit words), dut1 debiases (4-bit words); both use injected bits.
module tb_trng_word_sampler;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst;
    logic       en0, tb0, rdy0, valid0, fail0, busy0;
    logic [7:0] data0;
    logic       en1, tb1, rdy1, valid1, fail1, busy1;
    logic [3:0] data1;

    int errors = 0;
    int checks = 0;

    trng_word_sampler #(
        .NUM_OSCILLATORS (16), .NUM_INVERTER (5), .WORD_WIDTH (8),
        .DEBIAS (0), .WARMUP_CYCLES (4), .REP_LIMIT (32)
    ) dut0 (
        .clk (clk), .rst (rst), .enable (en0), .test_mode (1'b1), .test_bit (tb0),
        .data_o (data0), .valid_o (valid0), .ready_i (rdy0),
        .health_fail_o (fail0), .busy_o (busy0)
    );

    trng_word_sampler #(
        .NUM_OSCILLATORS (16), .NUM_INVERTER (5), .WORD_WIDTH (4),
        .DEBIAS (1), .WARMUP_CYCLES (4), .REP_LIMIT (32)
    ) dut1 (
        .clk (clk), .rst (rst), .enable (en1), .test_mode (1'b1), .test_bit (tb1),
        .data_o (data1), .valid_o (valid1), .ready_i (rdy1),
        .health_fail_o (fail1), .busy_o (busy1)
    );

    typedef struct {
        bit          sel;
        int          n;
        logic [63:0] bits;
        logic [63:0] exp;
    } vec_t;

    vec_t vecs[6];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic set_bit(input bit sel, input logic b);
        if (sel) tb1 = b;
        else     tb0 = b;
    endtask

    function automatic logic [63:0] sel_valid(input bit sel);
        return sel ? 64'(valid1) : 64'(valid0);
    endfunction

    function automatic logic [63:0] sel_busy(input bit sel);
        return sel ? 64'(busy1) : 64'(busy0);
    endfunction

    // The first edge of this task must be the one that enters COLLECT (warm-up end or handshake).
    task automatic feed(input bit sel, input int n, input logic [63:0] bits);
        set_bit(sel, bits[n-1]);
        @(posedge clk); #1;
        rdy0 = 1'b0;
        rdy1 = 1'b0;
        check("valid_low_at_collect", sel_valid(sel), 64'd0);
        check("busy_in_collect", sel_busy(sel), 64'd1);
        for (int k = 1; k < n; k++) begin
            set_bit(sel, bits[n-1-k]);
            @(posedge clk); #1;
        end
        check("valid_low_before_last", sel_valid(sel), 64'd0);
        @(posedge clk); #1;
    endtask

    initial begin
        vecs[0] = '{1'b0, 8,  64'h5A,  64'h5A};
        vecs[1] = '{1'b0, 8,  64'h0F,  64'h0F};
        vecs[2] = '{1'b0, 8,  64'hC3,  64'hC3};
        vecs[3] = '{1'b0, 8,  64'h96,  64'h96};
        vecs[4] = '{1'b1, 8,  64'h66,  64'h5};
        vecs[5] = '{1'b1, 12, 64'hA1D, 64'hC};

        rst = 1'b1;
        en0 = 1'b0; tb0 = 1'b0; rdy0 = 1'b0;
        en1 = 1'b0; tb1 = 1'b0; rdy1 = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_data0", 64'(data0), 64'd0);
        check("rst_valid0", 64'(valid0), 64'd0);
        check("rst_fail0", 64'(fail0), 64'd0);
        check("rst_busy0", 64'(busy0), 64'd0);
        check("rst_data1", 64'(data1), 64'd0);
        check("rst_valid1", 64'(valid1), 64'd0);
        rst = 1'b0;
        @(posedge clk); #1;

        // Raw 8-bit word from 1,0,1,1,0,0,1,0.
        en0 = 1'b1;
        repeat (4) @(posedge clk);
        #1;
        feed(1'b0, 8, 64'hB2);
        check("raw_word_valid", 64'(valid0), 64'd1);
        check("raw_word_data", 64'(data0), 64'hB2);
        check("hold_not_busy", 64'(busy0), 64'd0);

        // Consumer stalls for 20 cycles while the raw input keeps toggling.
        for (int c = 0; c < 20; c++) begin
            tb0 = ~tb0;
            @(posedge clk); #1;
            check("stall_data", 64'(data0), 64'hB2);
            check("stall_valid", 64'(valid0), 64'd1);
        end

        // Debiased word: pairs 10,01,11,10,00,01 give 1,0,-,1,-,0.
        en1 = 1'b1;
        repeat (4) @(posedge clk);
        #1;
        feed(1'b1, 12, 64'h9E1);
        check("debias_word_valid", 64'(valid1), 64'd1);
        check("debias_word_data", 64'(data1), 64'hA);

        for (int i = 0; i < 6; i++) begin
            if (vecs[i].sel) rdy1 = 1'b1;
            else             rdy0 = 1'b1;
            feed(vecs[i].sel, vecs[i].n, vecs[i].bits);
            check("vec_valid", sel_valid(vecs[i].sel), 64'd1);
            check("vec_busy", sel_busy(vecs[i].sel), 64'd0);
            check("vec_data", vecs[i].sel ? 64'(data1) : 64'(data0), vecs[i].exp);
        end

        // Abort after 5 of 8 bits; the next word must hold only fresh bits.
        rdy0 = 1'b1;
        feed(1'b0, 5, 64'h15);
        en0 = 1'b0;
        @(posedge clk); #1;
        check("abort_idle_busy", 64'(busy0), 64'd0);
        check("abort_valid", 64'(valid0), 64'd0);
        en0 = 1'b1;
        repeat (4) @(posedge clk);
        #1;
        feed(1'b0, 8, 64'h3C);
        check("reenable_valid", 64'(valid0), 64'd1);
        check("reenable_data", 64'(data0), 64'h3C);

        // Repetition test: a 0 then 31 ones is still healthy; the 32nd one trips it.
        rdy1 = 1'b1;
        feed(1'b1, 32, 64'h7FFF_FFFF);
        check("rep_31_no_fail", 64'(fail1), 64'd0);
        check("rep_31_busy", 64'(busy1), 64'd1);
        @(posedge clk); #1;
        check("rep_32_fail", 64'(fail1), 64'd1);
        check("rep_32_valid", 64'(valid1), 64'd0);
        check("rep_32_data", 64'(data1), 64'd0);
        check("rep_32_not_busy", 64'(busy1), 64'd0);
        en1 = 1'b0;
        repeat (3) @(posedge clk);
        en1 = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("fail_sticky", 64'(fail1), 64'd1);
        check("fail_stays_out", 64'(busy1), 64'd0);

        // Asynchronous reset in the middle of a cycle while dut0 holds a word.
        @(posedge clk); #3;
        check("pre_rst_valid", 64'(valid0), 64'd1);
        rst = 1'b1;
        #1;
        check("async_rst_valid", 64'(valid0), 64'd0);
        check("async_rst_data", 64'(data0), 64'd0);
        check("async_rst_fail1", 64'(fail1), 64'd0);
        check("async_rst_busy1", 64'(busy1), 64'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk); #1;

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
